rv32i_fetch_queue: RTL and testbench
====================================

RV32I_FETCH_QUEUE -- requirements
Module: rv32i_fetch_queue

Interface
REQ-001 SHALL have parameter DPW, default 32, instruction and PC width in bits.
REQ-002 SHALL have parameter ELEM_WIDTH, default 8, instruction-memory element width; DPW SHALL be a multiple of ELEM_WIDTH; BPI = DPW/ELEM_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 120, memory elements; DEPTH SHALL be a multiple of BPI; AW = $clog2(DEPTH).
REQ-004 SHALL have parameter QDEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset; synchronous, active-low.
REQ-007 prog_we  in  1  program-write strobe.
REQ-008 prog_addr  in  AW  program-write element address.
REQ-009 prog_data  in  ELEM_WIDTH  program-write data.
REQ-010 fetch_en  in  1  enables fetching.
REQ-011 redirect_valid  in  1  flush queue and restart fetch at redirect_pc.
REQ-012 redirect_pc  in  DPW  redirect target, element-addressed.
REQ-013 instr_valid  out  1  queue head valid.
REQ-014 instr_ready  in  1  consumer accepts head.
REQ-015 instr_o  out  DPW  head instruction.
REQ-016 pc_o  out  DPW  address of head instruction's first element.
REQ-017 q_count  out  $clog2(QDEPTH)+1  occupied queue entries.

Function
REQ-018 Memory: DEPTH x ELEM_WIDTH array, combinational read, not reset; prog_we writes mem[prog_addr] at edge; prog_addr >= DEPTH ignored.
REQ-019 Same-cycle write and fetch read of one element: fetch SHALL get old data; queued entries are never altered by writes.
REQ-020 FSM states: IDLE, FETCH, HOLD.
REQ-021 IDLE: no reads; goes FETCH when fetch_en=1.
REQ-022 FETCH: one element per cycle, mem[fpc+k], k=0..BPI-1; element k placed at bits [k*ELEM_WIDTH +: ELEM_WIDTH] (little-endian).
REQ-023 At k=BPI-1: if space (q_count<QDEPTH, or a pop same cycle) push {word, fpc}, fpc += BPI, k=0; stay FETCH if fetch_en else IDLE.
REQ-024 At k=BPI-1 with no space: go HOLD with assembled word held; HOLD pushes on first cycle with space, then as REQ-023.
REQ-025 fetch_en deassert mid-word: current word SHALL complete and push; then IDLE.
REQ-026 fpc wrap: if fpc+BPI >= DEPTH, next fpc = 0.
REQ-027 Queue: FIFO; push and pop same cycle legal at any count, count unchanged; pop = instr_valid & instr_ready; instr_valid = (q_count != 0).
REQ-028 instr_o/pc_o SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-029 Latency: word started in cycle t is visible with instr_valid=1 in cycle t+BPI (empty queue).
REQ-030 Redirect priority over all: q_count=0, partial/held word discarded, k=0, fpc = redirect_pc with low $clog2(BPI) bits cleared; redirect_pc >= DEPTH gives fpc=0; next state FETCH if fetch_en else IDLE.
REQ-031 Pop coincident with redirect SHALL be discarded (no effect); consumer ignores that transfer.

Reset
REQ-032 rst_n=0 at edge: state IDLE, fpc=0, k=0, q_count=0, instr_valid=0, instr_o=0, pc_o=0; memory retained.
REQ-033 Reset mid-word or in HOLD SHALL drop all in-flight data; first word after reset starts at fpc=0.

Verification
REQ-034 Load bytes 0..7 = 13 00 00 00 93 00 10 00, fetch_en=1, instr_ready=1 -> instr_o=0x00000013 pc_o=0 at cycle 4, instr_o=0x00100093 pc_o=4 at cycle 8.
REQ-035 instr_ready=0, fetch_en=1 -> q_count climbs to 4, FSM enters HOLD with pc 16 word; one pop -> held word pushed same cycle, q_count stays 4.
REQ-036 Redirect to 0x00000006 with q_count=3 and pop asserted -> q_count=0 next cycle, next instr pc_o=4, no entry from old stream appears.
REQ-037 Free-run from pc 112 -> pc_o sequence 112, 116, 0, 4.
REQ-038 rst_n=0 during k=2 of a word -> all outputs 0 next cycle; after release, first instr pc_o=0.
REQ-039 prog_we to element 0 in the cycle it is fetched -> queued word carries old byte; refetch after redirect to 0 carries new byte.

Source files
------------

// File: rtl/rv32i_fetch_queue_if.sv
// Instruction stream between the fetch queue and its consumer.
//   instr_valid : queue head holds a valid instruction (driven by queue)
//   instr_ready : consumer accepts the head this cycle (driven by consumer)
//   instr_o     : head instruction word
//   pc_o        : element address of the head instruction's first element
//   q_count     : number of occupied queue entries
interface rv32i_fetch_queue_if #(
   parameter int DPW    = 32,
   parameter int QDEPTH = 4
);
   localparam int CW = $clog2(QDEPTH) + 1;

   logic           instr_valid;
   logic           instr_ready;
   logic [DPW-1:0] instr_o;
   logic [DPW-1:0] pc_o;
   logic [CW-1:0]  q_count;

   modport master (
      output instr_valid,
      output instr_o,
      output pc_o,
      output q_count,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_o,
      input  pc_o,
      input  q_count,
      output instr_ready
   );
endinterface

// File: rtl/rv32i_fetch_queue.sv
// RV32I instruction fetch unit with a small instruction queue.
// A program memory of DEPTH elements (ELEM_WIDTH bits each) is loaded through
// the prog_* port. The fetch FSM reads one element per cycle, assembles
// BPI elements little-endian into one instruction and pushes it, together with
// its address, into a QDEPTH-entry FIFO that is presented on the iq stream.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   prog_we/addr/data   : program-memory write port
//   fetch_en            : allow new words to be started
//   redirect_valid/pc   : flush the queue and restart fetch at redirect_pc
//   iq (master)         : instr_valid/ready, instr_o, pc_o, q_count
module rv32i_fetch_queue #(
   parameter  int DPW        = 32,
   parameter  int ELEM_WIDTH = 8,
   parameter  int DEPTH      = 120,
   parameter  int QDEPTH     = 4,
   localparam int BPI        = DPW / ELEM_WIDTH,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  prog_we,
   input  logic [AW-1:0]         prog_addr,
   input  logic [ELEM_WIDTH-1:0] prog_data,
   input  logic                  fetch_en,
   input  logic                  redirect_valid,
   input  logic [DPW-1:0]        redirect_pc,
   rv32i_fetch_queue_if.master   iq
);

   localparam int KW = (BPI > 1) ? $clog2(BPI) : 1;
   localparam int QW = $clog2(QDEPTH);
   localparam int CW = QW + 1;
   localparam logic [KW-1:0] K_LAST = KW'(BPI - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic [DPW-1:0]        fpc_q, fpc_d;
   logic [DPW-1:0]        word_q, word_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DPW-1:0]        qi_q [QDEPTH];
   logic [DPW-1:0]        qi_d [QDEPTH];
   logic [DPW-1:0]        qp_q [QDEPTH];
   logic [DPW-1:0]        qp_d [QDEPTH];
   logic [ELEM_WIDTH-1:0] mem_q [DEPTH];

   logic [AW-1:0]         rd_addr_s;
   logic [ELEM_WIDTH-1:0] rd_elem_s;
   logic [DPW-1:0]        word_asm_s;
   logic [DPW-1:0]        next_fpc_s;
   logic [DPW-1:0]        redir_fpc_s;
   logic                  pop_s;
   logic                  space_s;
   logic                  push_s;
   logic [DPW-1:0]        push_word_s;
   logic [DPW-1:0]        push_pc_s;
   logic [CW-1:0]         push_idx_s;

   // fpc is always BPI-aligned and below DEPTH, so fpc+k never leaves the array
   assign rd_addr_s   = fpc_q[AW-1:0] + AW'(k_q);
   assign rd_elem_s   = mem_q[rd_addr_s];
   assign next_fpc_s  = ((fpc_q + DPW'(BPI)) >= DPW'(DEPTH)) ? '0 : (fpc_q + DPW'(BPI));
   assign redir_fpc_s = (redirect_pc >= DPW'(DEPTH)) ? '0 : (redirect_pc & ~DPW'(BPI - 1));

   // a pop that coincides with a redirect is dropped together with the queue
   assign pop_s   = (count_q != '0) && iq.instr_ready && !redirect_valid;
   assign space_s = (count_q < CW'(QDEPTH)) || pop_s;

   // the head entry is itself a register, so the stream outputs are registered
   assign iq.instr_valid = (count_q != '0);
   assign iq.instr_o     = qi_q[0];
   assign iq.pc_o        = qp_q[0];
   assign iq.q_count     = count_q;

   // program memory write port; out-of-range addresses are ignored, no reset
   always_ff @(posedge clk) begin
      if (prog_we && ({1'b0, prog_addr} < (AW+1)'(DEPTH))) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   // merge the element read this cycle into the partially assembled word
   always_comb begin
      word_asm_s = word_q;
      for (int b = 0; b < BPI; b++) begin
         if (k_q == KW'(b)) begin
            word_asm_s[b*ELEM_WIDTH +: ELEM_WIDTH] = rd_elem_s;
         end else begin
            word_asm_s[b*ELEM_WIDTH +: ELEM_WIDTH] = word_q[b*ELEM_WIDTH +: ELEM_WIDTH];
         end
      end
   end

   // fetch FSM next-state logic and queue push request
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      fpc_d       = fpc_q;
      word_d      = word_q;
      push_s      = 1'b0;
      push_word_s = word_asm_s;
      push_pc_s   = fpc_q;
      if (redirect_valid) begin
         state_d = fetch_en ? ST_FETCH : ST_IDLE;
         k_d     = '0;
         fpc_d   = redir_fpc_s;
         word_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fetch_en) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_FETCH: begin
               // a started word always completes, even if fetch_en drops
               word_d = word_asm_s;
               if (k_q == K_LAST) begin
                  k_d = '0;
                  if (space_s) begin
                     push_s  = 1'b1;
                     fpc_d   = next_fpc_s;
                     state_d = fetch_en ? ST_FETCH : ST_IDLE;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
            ST_HOLD: begin
               push_word_s = word_q;
               if (space_s) begin
                  push_s  = 1'b1;
                  fpc_d   = next_fpc_s;
                  state_d = fetch_en ? ST_FETCH : ST_IDLE;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // shift-register FIFO: entry 0 is the head, unused entries are kept at zero
   always_comb begin
      qi_d       = qi_q;
      qp_d       = qp_q;
      count_d    = count_q;
      push_idx_s = count_q;
      if (redirect_valid) begin
         for (int i = 0; i < QDEPTH; i++) begin
            qi_d[i] = '0;
            qp_d[i] = '0;
         end
         count_d = '0;
      end else begin
         if (pop_s) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
               qi_d[i] = qi_q[i+1];
               qp_d[i] = qp_q[i+1];
            end
            qi_d[QDEPTH-1] = '0;
            qp_d[QDEPTH-1] = '0;
            push_idx_s     = count_q - CW'(1);
         end else begin
            push_idx_s = count_q;
         end
         if (push_s) begin
            qi_d[push_idx_s[QW-1:0]] = push_word_s;
            qp_d[push_idx_s[QW-1:0]] = push_pc_s;
         end else begin
            qi_d[0] = qi_d[0];
         end
         count_d = count_q + CW'(push_s) - CW'(pop_s);
      end
   end

   // state, fetch pointer, assembly buffer and queue registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         fpc_q   <= '0;
         word_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            qi_q[i] <= '0;
            qp_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         fpc_q   <= fpc_d;
         word_q  <= word_d;
         count_q <= count_d;
         for (int i = 0; i < QDEPTH; i++) begin
            qi_q[i] <= qi_d[i];
            qp_q[i] <= qp_d[i];
         end
      end
   end

endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// Directed bench for rv32i_fetch_queue: a cycle table for the first fetches
// plus hand-written sequences for stall/hold, redirect, wrap, reset and
// write/fetch ordering. Expected words come from a shadow copy of the
// program the bench loads.
module tb_rv32i_fetch_queue;

   localparam int DEPTH = 120;

   typedef struct packed {
      logic        fe;
      logic        rdy;
      logic        ev;
      logic [31:0] ei;
      logic [31:0] ep;
      logic [2:0]  ec;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        prog_we;
   logic [6:0]  prog_addr;
   logic [7:0]  prog_data;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   logic [7:0]  tb_mem [DEPTH];
   vec_t        vt [9];
   int          n_checks;
   int          n_errors;

   rv32i_fetch_queue_if #(.DPW(32), .QDEPTH(4)) iq ();

   rv32i_fetch_queue #(
      .DPW(32), .ELEM_WIDTH(8), .DEPTH(DEPTH), .QDEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .iq(iq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int p);
      return {tb_mem[p+3], tb_mem[p+2], tb_mem[p+1], tb_mem[p]};
   endfunction

   task automatic do_redirect(input logic [31:0] pc, input logic fe, input logic rdy);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      fetch_en       = fe;
      iq.instr_ready = rdy;
      step();
      redirect_valid = 1'b0;
   endtask

   task automatic wait_count(input int target, input string name);
      int n;
      n = 0;
      while (n < 60 && int'(iq.q_count) != target) begin
         step();
         n++;
      end
      chk(name, 32'(iq.q_count), 32'(target));
   endtask

   // consume the next instruction and compare it with the expected address
   task automatic pop_expect(input int p, input string name);
      bit got;
      got = 1'b0;
      iq.instr_ready = 1'b1;
      for (int i = 0; i < 40 && !got; i++) begin
         if (iq.instr_valid) begin
            chk({name, "_pc"}, iq.pc_o, 32'(p));
            chk({name, "_instr"}, iq.instr_o, exp_word(p));
            got = 1'b1;
         end
         step();
      end
      if (!got) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: got no instruction in 40 cycles expected pc %0d", name, p);
      end
   endtask

   initial begin
      logic [31:0] hold_instr;
      logic [31:0] hold_pc;
      n_checks       = 0;
      n_errors       = 0;
      rst_n          = 1'b0;
      prog_we        = 1'b0;
      prog_addr      = 7'd0;
      prog_data      = 8'd0;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      iq.instr_ready = 1'b0;

      // program image: two known RV32I words, then byte a holds value a
      for (int a = 0; a < DEPTH; a++) tb_mem[a] = 8'(a);
      tb_mem[0] = 8'h13; tb_mem[1] = 8'h00; tb_mem[2] = 8'h00; tb_mem[3] = 8'h00;
      tb_mem[4] = 8'h93; tb_mem[5] = 8'h00; tb_mem[6] = 8'h10; tb_mem[7] = 8'h00;

      // cycle table: fetch from reset with consumer always ready
      for (int j = 0; j < 9; j++) vt[j] = '{fe: 1'b1, rdy: 1'b1, ev: 1'b0, ei: 32'd0, ep: 32'd0, ec: 3'd0};
      vt[4] = '{fe: 1'b1, rdy: 1'b1, ev: 1'b1, ei: 32'h0000_0013, ep: 32'd0, ec: 3'd1};
      vt[8] = '{fe: 1'b1, rdy: 1'b1, ev: 1'b1, ei: 32'h0010_0093, ep: 32'd4, ec: 3'd1};

      step();
      step();
      chk("rst_valid", 32'(iq.instr_valid), 32'd0);
      chk("rst_instr", iq.instr_o, 32'd0);
      chk("rst_pc", iq.pc_o, 32'd0);
      chk("rst_count", 32'(iq.q_count), 32'd0);

      rst_n = 1'b1;
      for (int a = 0; a < DEPTH; a++) begin
         prog_we   = 1'b1;
         prog_addr = 7'(a);
         prog_data = tb_mem[a];
         step();
      end
      prog_we = 1'b0;
      step();
      chk("idle_valid", 32'(iq.instr_valid), 32'd0);

      for (int j = 0; j < 9; j++) begin
         fetch_en       = vt[j].fe;
         iq.instr_ready = vt[j].rdy;
         step();
         chk($sformatf("vec%0d_valid", j), 32'(iq.instr_valid), 32'(vt[j].ev));
         chk($sformatf("vec%0d_count", j), 32'(iq.q_count), 32'(vt[j].ec));
         if (vt[j].ev) begin
            chk($sformatf("vec%0d_instr", j), iq.instr_o, vt[j].ei);
            chk($sformatf("vec%0d_pc", j), iq.pc_o, vt[j].ep);
         end
      end

      // stall: queue fills with 0,4,8,12 and the pc 16 word waits in HOLD
      do_redirect(32'd0, 1'b1, 1'b0);
      chk("stall_flush_count", 32'(iq.q_count), 32'd0);
      repeat (16) step();
      chk("stall_full_count", 32'(iq.q_count), 32'd4);
      hold_instr = iq.instr_o;
      hold_pc    = iq.pc_o;
      chk("stall_head_pc", hold_pc, 32'd0);
      repeat (6) step();
      chk("stall_stable_instr", iq.instr_o, hold_instr);
      chk("stall_stable_pc", iq.pc_o, hold_pc);
      chk("stall_stable_count", 32'(iq.q_count), 32'd4);
      iq.instr_ready = 1'b1;
      step();
      chk("hold_push_count", 32'(iq.q_count), 32'd4);
      // fetch_en drops during the pc 20 word: it still completes, then nothing more
      fetch_en = 1'b0;
      pop_expect(4, "drain4");
      pop_expect(8, "drain8");
      pop_expect(12, "drain12");
      pop_expect(16, "drain16");
      pop_expect(20, "drain20");
      repeat (8) step();
      chk("drain_empty_valid", 32'(iq.instr_valid), 32'd0);

      // redirect to an unaligned target while popping a three-entry queue
      do_redirect(32'd0, 1'b1, 1'b0);
      wait_count(3, "redir_fill_count");
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0006;
      iq.instr_ready = 1'b1;
      step();
      redirect_valid = 1'b0;
      chk("redir_count", 32'(iq.q_count), 32'd0);
      chk("redir_valid", 32'(iq.instr_valid), 32'd0);
      pop_expect(4, "redir_first");
      pop_expect(8, "redir_second");

      // fetch pointer wraps at the end of memory
      do_redirect(32'd112, 1'b1, 1'b1);
      pop_expect(112, "wrap112");
      pop_expect(116, "wrap116");
      pop_expect(0, "wrap0");
      pop_expect(4, "wrap4");

      // reset in the middle of a word with one entry queued
      do_redirect(32'd40, 1'b1, 1'b0);
      wait_count(1, "mid_fill_count");
      step();
      step();
      rst_n = 1'b0;
      step();
      chk("midrst_valid", 32'(iq.instr_valid), 32'd0);
      chk("midrst_instr", iq.instr_o, 32'd0);
      chk("midrst_pc", iq.pc_o, 32'd0);
      chk("midrst_count", 32'(iq.q_count), 32'd0);
      rst_n    = 1'b1;
      fetch_en = 1'b1;
      pop_expect(0, "after_rst");

      // write element 0 in the same cycle it is fetched
      fetch_en       = 1'b0;
      iq.instr_ready = 1'b1;
      repeat (12) step();
      chk("pre_wr_count", 32'(iq.q_count), 32'd0);
      do_redirect(32'd0, 1'b1, 1'b0);
      fetch_en  = 1'b0;
      prog_we   = 1'b1;
      prog_addr = 7'd0;
      prog_data = 8'hA5;
      step();
      prog_we = 1'b0;
      wait_count(1, "wr_old_count");
      chk("wr_old_instr", iq.instr_o, 32'h0000_0013);
      chk("wr_old_pc", iq.pc_o, 32'd0);
      tb_mem[0] = 8'hA5;
      do_redirect(32'd0, 1'b1, 1'b1);
      pop_expect(0, "wr_new");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
